// File: rtl/systolic_feed_ctrl_if.sv
// rtl/systolic_feed_ctrl_if.sv - control/read bus between feed sequencer, operand buffers and skew/array datapath
interface systolic_feed_ctrl_if #(
  parameter int ADDR_W = 1,
  parameter int CNT_W  = 32
);
  logic              start;
  logic              src_valid;
  logic              busy;
  logic              done;
  logic              clear_acc;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              feed_zero;
  logic              enable_out;
  logic [CNT_W-1:0]  busy_cycles;

  // sequencer side
  modport master (
    input  start, src_valid,
    output busy, done, clear_acc, rd_en, rd_addr, feed_zero, enable_out, busy_cycles
  );

  // requester / datapath side
  modport slave (
    output start, src_valid,
    input  busy, done, clear_acc, rd_en, rd_addr, feed_zero, enable_out, busy_cycles
  );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - sequencer for one NxN systolic matrix multiply
module systolic_feed_ctrl #(
  parameter int MATRIX_SIZE = 2,
  parameter int ADDR_W      = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  systolic_feed_ctrl_if.master bus
);

  // one shared counter serves FEED (0..N-1) and FLUSH (0..2N-2)
  localparam int CW = (MATRIX_SIZE > 1) ? $clog2(2 * MATRIX_SIZE - 1) : 1;
  localparam logic [CW-1:0] FEED_LAST  = CW'(MATRIX_SIZE - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * MATRIX_SIZE - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] busy_cycles_q, busy_cycles_d;

  // state, shared counter and busy-cycle counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      busy_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_cycles_q <= busy_cycles_d;
    end
  end

  // next-state, counter updates and output decode
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    busy_cycles_d  = busy_cycles_q;
    bus.busy       = 1'b1;
    bus.done       = 1'b0;
    bus.clear_acc  = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.feed_zero  = 1'b0;
    bus.enable_out = 1'b0;

    // saturating count of every busy cycle, stalls included
    if (state_q != S_IDLE && busy_cycles_q != {CNT_W{1'b1}}) begin
      busy_cycles_d = busy_cycles_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          state_d       = S_CLEAR;
          busy_cycles_d = '0;
        end
      end
      S_CLEAR: begin
        bus.clear_acc = 1'b1;
        state_d       = S_FEED;
        cnt_d         = '0;
      end
      S_FEED: begin
        bus.rd_en      = 1'b1;
        bus.rd_addr    = cnt_q[ADDR_W-1:0];
        // a missing operand freezes the skew/array and holds the index
        bus.enable_out = bus.src_valid;
        if (bus.src_valid) begin
          if (cnt_q == FEED_LAST) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        // zeros push the last operands through skew and array
        bus.feed_zero  = 1'b1;
        bus.enable_out = 1'b1;
        if (cnt_q == FLUSH_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.busy_cycles = busy_cycles_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb/tb_systolic_feed_ctrl.sv - scoreboard bench for systolic_feed_ctrl at N=4, 2, 1 and 8 (saturating)
module tb_systolic_feed_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_feed_ctrl_if #(.ADDR_W(2), .CNT_W(32)) if4 ();
  systolic_feed_ctrl_if #(.ADDR_W(1), .CNT_W(32)) if2 ();
  systolic_feed_ctrl_if #(.ADDR_W(1), .CNT_W(32)) if1 ();
  systolic_feed_ctrl_if #(.ADDR_W(3), .CNT_W(4))  if8 ();

  systolic_feed_ctrl #(.MATRIX_SIZE(4), .ADDR_W(2), .CNT_W(32)) u4 (.clk(clk), .reset(reset), .bus(if4.master));
  systolic_feed_ctrl #(.MATRIX_SIZE(2), .ADDR_W(1), .CNT_W(32)) u2 (.clk(clk), .reset(reset), .bus(if2.master));
  systolic_feed_ctrl #(.MATRIX_SIZE(1), .ADDR_W(1), .CNT_W(32)) u1 (.clk(clk), .reset(reset), .bus(if1.master));
  systolic_feed_ctrl #(.MATRIX_SIZE(8), .ADDR_W(3), .CNT_W(4))  u8 (.clk(clk), .reset(reset), .bus(if8.master));

  // per-instance stimulus and flattened observation: {busy,done,clear,rd_en,feed_zero,enable,rd_addr[7:0]}
  logic [3:0]        start_v, src_v;
  logic [3:0][13:0]  obs;
  logic [3:0][31:0]  bcv;

  assign if4.start = start_v[0]; assign if4.src_valid = src_v[0];
  assign if2.start = start_v[1]; assign if2.src_valid = src_v[1];
  assign if1.start = start_v[2]; assign if1.src_valid = src_v[2];
  assign if8.start = start_v[3]; assign if8.src_valid = src_v[3];

  assign obs[0] = {if4.busy, if4.done, if4.clear_acc, if4.rd_en, if4.feed_zero, if4.enable_out, 8'(if4.rd_addr)};
  assign obs[1] = {if2.busy, if2.done, if2.clear_acc, if2.rd_en, if2.feed_zero, if2.enable_out, 8'(if2.rd_addr)};
  assign obs[2] = {if1.busy, if1.done, if1.clear_acc, if1.rd_en, if1.feed_zero, if1.enable_out, 8'(if1.rd_addr)};
  assign obs[3] = {if8.busy, if8.done, if8.clear_acc, if8.rd_en, if8.feed_zero, if8.enable_out, 8'(if8.rd_addr)};
  assign bcv[0] = if4.busy_cycles;
  assign bcv[1] = if2.busy_cycles;
  assign bcv[2] = if1.busy_cycles;
  assign bcv[3] = 32'(if8.busy_cycles);

  typedef struct packed {
    logic        st;
    logic        src;
    logic [13:0] exp;
    logic [31:0] ebc;
  } item_t;

  item_t       sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_bc[4];

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] sat(input int x, input int cmax);
    return (x > cmax) ? 32'(cmax) : 32'(x);
  endfunction

  // expected per-cycle trace of one operation, starting with the IDLE cycle that carries start
  task automatic build(input int n, input int cmax, input int stall_addr, input int stall_len,
                       input logic poke, input logic [31:0] prev_bc, output logic [31:0] final_bc);
    int i;
    i = 0;
    sb.push_back('{st: 1'b1, src: 1'b0, exp: 14'd0, ebc: prev_bc});
    sb.push_back('{st: poke, src: 1'b0, exp: {6'b101000, 8'd0}, ebc: sat(i, cmax)}); i++;
    for (int a = 0; a < n; a++) begin
      if (a == stall_addr) begin
        for (int s = 0; s < stall_len; s++) begin
          sb.push_back('{st: poke, src: 1'b0, exp: {6'b100100, 8'(a)}, ebc: sat(i, cmax)}); i++;
        end
      end
      sb.push_back('{st: poke, src: 1'b1, exp: {6'b100101, 8'(a)}, ebc: sat(i, cmax)}); i++;
    end
    for (int f = 0; f < 2 * n - 1; f++) begin
      sb.push_back('{st: poke, src: 1'b0, exp: {6'b100011, 8'd0}, ebc: sat(i, cmax)}); i++;
    end
    sb.push_back('{st: poke, src: 1'b1, exp: {6'b110000, 8'd0}, ebc: sat(i, cmax)}); i++;
    final_bc = sat(i, cmax);
  endtask

  task automatic run(input int k, input int n, input int cmax, input int stall_addr, input int stall_len,
                     input logic poke, input int abort_idx, input logic tail);
    item_t       it;
    int          idx;
    logic [31:0] fbc;
    build(n, cmax, stall_addr, stall_len, poke, last_bc[k], fbc);
    idx = 0;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge clk);
      start_v[k] = it.st;
      src_v[k]   = it.src;
      #1;
      check($sformatf("k%0d.c%0d.ctl", k, idx), 32'(obs[k]), 32'(it.exp));
      check($sformatf("k%0d.c%0d.bcyc", k, idx), bcv[k], it.ebc);
      if (idx == abort_idx) begin
        #2 reset = 1'b1;
        #1;
        check($sformatf("k%0d.rst.ctl", k), 32'(obs[k]), 32'd0);
        check($sformatf("k%0d.rst.bcyc", k), bcv[k], 32'd0);
        sb.delete();
        start_v[k] = 1'b0;
        src_v[k]   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 4; j++) last_bc[j] = 32'd0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk); #1;
          check($sformatf("k%0d.postrst%0d.ctl", k, j), 32'(obs[k]), 32'd0);
        end
        return;
      end
      idx++;
    end
    last_bc[k] = fbc;
    if (tail) begin
      @(negedge clk);
      start_v[k] = 1'b0;
      src_v[k]   = 1'b0;
      #1;
      check($sformatf("k%0d.idle.ctl", k), 32'(obs[k]), 32'd0);
      check($sformatf("k%0d.idle.bcyc", k), bcv[k], fbc);
    end
  endtask

  initial begin
    start_v = '0;
    src_v   = '0;
    reset   = 1'b1;
    for (int j = 0; j < 4; j++) last_bc[j] = 32'd0;
    @(negedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("k%0d.reset.ctl", j), 32'(obs[j]), 32'd0);
      check($sformatf("k%0d.reset.bcyc", j), bcv[j], 32'd0);
    end
    reset = 1'b0;

    // N=4 clean run: 13 busy cycles
    run(0, 4, 32'h7fffffff, -1, 0, 1'b0, -1, 1'b1);
    // N=4 with two stall cycles at rd_addr=1: 15 busy cycles
    run(0, 4, 32'h7fffffff, 1, 2, 1'b0, -1, 1'b1);
    // N=2 with start held through FEED/FLUSH/DONE, then back-to-back start right after DONE
    run(1, 2, 32'h7fffffff, -1, 0, 1'b1, -1, 1'b0);
    run(1, 2, 32'h7fffffff, -1, 0, 1'b0, -1, 1'b1);
    // N=4 aborted by asynchronous reset in the third FLUSH cycle, then a normal run
    run(0, 4, 32'h7fffffff, -1, 0, 1'b0, 8, 1'b0);
    run(0, 4, 32'h7fffffff, -1, 0, 1'b0, -1, 1'b1);
    // N=1 boundary: 4 busy cycles
    run(2, 1, 32'h7fffffff, -1, 0, 1'b0, -1, 1'b1);
    // N=8 with a 4-bit counter: 25 busy cycles saturate at 15
    run(3, 8, 15, -1, 0, 1'b0, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
